// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: bundles the two requester ports and the synchronous SRAM
// port of sram_arbiter.
//
// Handshake: a requester raises reqN with weN/addrN/wdataN and holds all of
// them stable until it sees gntN=1 (a one-cycle pulse); the request is
// accepted on the edge that raises gntN. A read returns its word on rdataN
// together with a one-cycle rvalidN pulse; rdataN then holds until the next
// read for that requester. There is no back-pressure on rvalidN.
interface sram_arbiter_if #(
  parameter int DATA_BIT    = 8,
  parameter int ADDRESS_BIT = 4
);
  logic                   req0;
  logic                   req1;
  logic                   we0;
  logic                   we1;
  logic [ADDRESS_BIT-1:0] addr0;
  logic [ADDRESS_BIT-1:0] addr1;
  logic [DATA_BIT-1:0]    wdata0;
  logic [DATA_BIT-1:0]    wdata1;
  logic                   gnt0;
  logic                   gnt1;
  logic                   rvalid0;
  logic                   rvalid1;
  logic [DATA_BIT-1:0]    rdata0;
  logic [DATA_BIT-1:0]    rdata1;
  logic                   m_cs;
  logic                   m_we;
  logic [ADDRESS_BIT-1:0] m_addr;
  logic [DATA_BIT-1:0]    m_wdata;
  logic [DATA_BIT-1:0]    m_rdata;

  // Arbiter side.
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, m_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
    output m_cs, m_we, m_addr, m_wdata
  );

  // Requesters plus SRAM side.
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, m_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
    input  m_cs, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: two-requester arbiter in front of a single-port synchronous
// SRAM. One access at a time: IDLE picks a winner, ISSUE presents the access
// to the SRAM for one cycle, READ captures the returned word.
// Build option: define ARB_FIXED_PRIO_EN for fixed priority (requester 0
// wins ties); otherwise ties are resolved round-robin.
module sram_arbiter #(
  parameter int DATA_BIT    = 8,
  parameter int ADDRESS_BIT = 4
) (
  input  logic       ck,
  input  logic       rst,
  sram_arbiter_if.slave bus,
  output logic [1:0] state_dbg
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;

  logic [1:0]             state;
  logic                   win;
  logic                   sel;
  logic                   gnt0_q;
  logic                   gnt1_q;
  logic                   rvalid0_q;
  logic                   rvalid1_q;
  logic [DATA_BIT-1:0]    rdata0_q;
  logic [DATA_BIT-1:0]    rdata1_q;
  logic                   m_cs_q;
  logic                   m_we_q;
  logic [ADDRESS_BIT-1:0] m_addr_q;
  logic [DATA_BIT-1:0]    m_wdata_q;

`ifndef ARB_FIXED_PRIO_EN
  // Names the requester that wins the next tie.
  logic ptr;
`endif

  // Winner selection: a lone request always wins; a tie follows the policy.
  always_comb begin
    sel = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
    sel = ~bus.req0;
`else
    if (bus.req0 && bus.req1) sel = ptr;
    else                      sel = ~bus.req0;
`endif
  end

`ifndef ARB_FIXED_PRIO_EN
  // Round-robin pointer moves to the loser of every grant.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (state == S_IDLE && (bus.req0 || bus.req1)) begin
      ptr <= ~sel;
    end
  end
`endif

  // Access sequencer: accept, present to the SRAM, capture read data.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      win       <= 1'b0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      m_cs_q    <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
    end else begin
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.req0 || bus.req1) begin
            win       <= sel;
            gnt0_q    <= ~sel;
            gnt1_q    <= sel;
            m_cs_q    <= 1'b1;
            m_we_q    <= sel ? bus.we1    : bus.we0;
            m_addr_q  <= sel ? bus.addr1  : bus.addr0;
            m_wdata_q <= sel ? bus.wdata1 : bus.wdata0;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // The SRAM samples m_* on this edge; m_we/m_addr/m_wdata keep
          // their values while chip select is low.
          m_cs_q <= 1'b0;
          state  <= m_we_q ? S_IDLE : S_READ;
        end
        S_READ: begin
          // Only here is m_rdata guaranteed driven by the SRAM.
          if (win) begin
            rdata1_q  <= bus.m_rdata;
            rvalid1_q <= 1'b1;
          end else begin
            rdata0_q  <= bus.m_rdata;
            rvalid0_q <= 1'b1;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt0    = gnt0_q;
  assign bus.gnt1    = gnt1_q;
  assign bus.rvalid0 = rvalid0_q;
  assign bus.rvalid1 = rvalid1_q;
  assign bus.rdata0  = rdata0_q;
  assign bus.rdata1  = rdata1_q;
  assign bus.m_cs    = m_cs_q;
  assign bus.m_we    = m_we_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;
  assign state_dbg   = state;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed bench for sram_arbiter with a transaction-level
// model of the arbiter, a synchronous SRAM model and literal checks.
// Honours ARB_FIXED_PRIO_EN the same way as the design.
module tb_sram_arbiter;

  localparam int DW = 8;
  localparam int AW = 4;

  logic       ck = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] state_dbg;
  int         tb_cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  sram_arbiter_if #(.DATA_BIT(DW), .ADDRESS_BIT(AW)) bus();

  sram_arbiter #(.DATA_BIT(DW), .ADDRESS_BIT(AW)) dut (
    .ck        (ck),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 ck = ~ck;
  always @(posedge ck) tb_cyc <= tb_cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- SRAM model ----------------
  logic [DW-1:0] sram_mem [16];
  logic          rd_pend = 1'b0;
  logic [AW-1:0] rd_a = '0;
  logic [DW-1:0] m_rdata_drv = 'z;

  always @(posedge ck) begin
    rd_pend <= 1'b0;
    if (bus.m_cs) begin
      if (bus.m_we) sram_mem[bus.m_addr] <= bus.m_wdata;
      else begin
        rd_pend <= 1'b1;
        rd_a    <= bus.m_addr;
      end
    end
  end
  always @(negedge ck) m_rdata_drv = rd_pend ? sram_mem[rd_a] : 'z;
  assign bus.m_rdata = m_rdata_drv;

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, tb_cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // One access at a time; a write frees the port 2 cycles after accept, a
  // read 3 cycles after accept and returns data 2 cycles after accept.
  int            m_cyc, free_at, rv_at, rv_who;
  logic [AW-1:0] rv_addr;
  logic          ptr_m;
  logic [DW-1:0] mem_m [16];
  logic          e_gnt0, e_gnt1, e_rv0, e_rv1, e_cs, e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_rd0, e_rd1;

  always @(posedge ck or posedge rst) begin
    int w;
    if (rst) begin
      m_cyc = 0; free_at = 0; rv_at = -1; rv_who = 0; ptr_m = 1'b0;
      e_gnt0 = 0; e_gnt1 = 0; e_rv0 = 0; e_rv1 = 0; e_cs = 0; e_we = 0;
      e_addr = '0; e_wdata = '0; e_rd0 = '0; e_rd1 = '0;
    end else begin
      m_cyc++;
      e_gnt0 = 0; e_gnt1 = 0; e_rv0 = 0; e_rv1 = 0; e_cs = 0;
      if (m_cyc == rv_at) begin
        if (rv_who == 1) begin e_rv1 = 1; e_rd1 = mem_m[rv_addr]; end
        else             begin e_rv0 = 1; e_rd0 = mem_m[rv_addr]; end
      end
      if (m_cyc >= free_at && (bus.req0 || bus.req1)) begin
`ifdef ARB_FIXED_PRIO_EN
        w = bus.req0 ? 0 : 1;
`else
        w = (bus.req0 && bus.req1) ? int'(ptr_m) : (bus.req0 ? 0 : 1);
        ptr_m = (w == 0);
`endif
        if (w == 0) e_gnt0 = 1; else e_gnt1 = 1;
        e_cs    = 1;
        e_we    = (w == 0) ? bus.we0 : bus.we1;
        e_addr  = (w == 0) ? bus.addr0 : bus.addr1;
        e_wdata = (w == 0) ? bus.wdata0 : bus.wdata1;
        if (e_we) begin
          mem_m[e_addr] = e_wdata;
          free_at = m_cyc + 2;
        end else begin
          rv_at = m_cyc + 2; rv_who = w; rv_addr = e_addr;
          free_at = m_cyc + 3;
        end
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge ck) begin
    check("gnt0", bus.gnt0, e_gnt0);
    check("gnt1", bus.gnt1, e_gnt1);
    check("rvalid0", bus.rvalid0, e_rv0);
    check("rvalid1", bus.rvalid1, e_rv1);
    check("rdata0", bus.rdata0, e_rd0);
    check("rdata1", bus.rdata1, e_rd1);
    check("m_cs", bus.m_cs, e_cs);
    check("m_we", bus.m_we, e_we);
    check("m_addr", bus.m_addr, e_addr);
    check("m_wdata", bus.m_wdata, e_wdata);
    check("gnt_excl", bus.gnt0 & bus.gnt1, 1'b0);
    check("rvalid_excl", bus.rvalid0 & bus.rvalid1, 1'b0);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic set_req(input int who, input logic r, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (who == 0) begin
      bus.req0 = r; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = r; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
    end
  endtask

  task automatic wait_gnt(input int who);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if ((who == 0 && bus.gnt0) || (who == 1 && bus.gnt1)) begin
        ok = 1'b1;
        if (who == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
      end
    end
    check("gnt_wait", ok, 1'b1);
  endtask

  // ---------------- scoreboard / directed stimulus ----------------
  logic [DW-1:0] exp_q [$];

  initial begin
    int g0, g1, rv1;
    logic [DW-1:0] rd1;
    int gw [4];
    int gc [4];
    int ng;
    logic got;
    logic [DW-1:0] e;

    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;

    // Reset state
    tick(); tick();
    check("rst_m_cs", bus.m_cs, 1'b0);
    check("rst_rdata0", bus.rdata0, 8'h00);
    check("rst_state", state_dbg, 2'd0);
    rst = 1'b0;

    // Write by 0 and read by 1 raised together: write wins the tie
    set_req(0, 1, 1, 4'd3, 8'hA5);
    set_req(1, 1, 0, 4'd3, 8'h00);
    g0 = -1; g1 = -1; rv1 = -1; rd1 = '0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.gnt0) begin g0 = tb_cyc; bus.req0 = 1'b0; end
      if (bus.gnt1) begin g1 = tb_cyc; bus.req1 = 1'b0; end
      if (bus.rvalid1) begin rv1 = tb_cyc; rd1 = bus.rdata1; end
    end
    check("wr_rd_gnt0_seen", (g0 >= 0), 1'b1);
    check("wr_rd_gnt_gap", g1 - g0, 2);
    check("wr_rd_rvalid_gap", rv1 - g1, 2);
    check("wr_rd_data", rd1, 8'hA5);

    // Both read, held continuously
    set_req(0, 1, 0, 4'd3, 8'h00);
    set_req(1, 1, 0, 4'd3, 8'h00);
    ng = 0;
    for (int i = 0; i < 20 && ng < 4; i++) begin
      tick();
      if (bus.gnt0) begin gw[ng] = 0; gc[ng] = tb_cyc; ng++; end
      else if (bus.gnt1) begin gw[ng] = 1; gc[ng] = tb_cyc; ng++; end
    end
    bus.req0 = 0; bus.req1 = 0;
    check("rr_count", ng, 4);
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_FIXED_PRIO_EN
      check("rr_who", gw[i], 0);
`else
      check("rr_who", gw[i], i % 2);
`endif
      if (i > 0) check("rr_spacing", gc[i] - gc[i-1], 3);
    end
    repeat (4) tick();

    // Fill 0..15 with address*17, then read all back
    for (int a = 0; a < 16; a++) begin
      set_req(0, 1, 1, AW'(a), DW'(a * 17));
      wait_gnt(0);
    end
    for (int a = 0; a < 16; a++) begin
      exp_q.push_back(DW'(a * 17));
      set_req(1, 1, 0, AW'(a), 8'h00);
      wait_gnt(1);
      got = 1'b0;
      for (int i = 0; i < 5 && !got; i++) begin
        if (bus.rvalid1) got = 1'b1;
        else tick();
      end
      check("fill_rvalid_seen", got, 1'b1);
      e = exp_q.pop_front();
      check("fill_rdata", bus.rdata1, e);
      check("fill_no_xz", $isunknown(bus.rdata1), 1'b0);
    end

    // Idle bus for 10 cycles
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_m_cs", bus.m_cs, 1'b0);
      check("idle_rdata1_hold", bus.rdata1, 8'hFF);
    end

    // Reset during ISSUE of a read; requester 0 won last, so without reset
    // the next tie would go to requester 1.
    set_req(0, 1, 0, 4'd5, 8'h00);
    wait_gnt(0);
    #1 rst = 1'b1;
    #1;
    check("abort_m_cs", bus.m_cs, 1'b0);
    check("abort_gnt0", bus.gnt0, 1'b0);
    check("abort_state", state_dbg, 2'd0);
    tick();
    rst = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.rvalid0 || bus.rvalid1) got = 1'b1;
    end
    check("abort_no_rvalid", got, 1'b0);
    set_req(0, 1, 0, 4'd1, 8'h00);
    set_req(1, 1, 0, 4'd2, 8'h00);
    g0 = -1;
    for (int i = 0; i < 6 && g0 < 0; i++) begin
      tick();
      if (bus.gnt0) g0 = 0;
      else if (bus.gnt1) g0 = 1;
    end
    check("post_rst_tie", g0, 0);
    bus.req0 = 0;
    wait_gnt(1);
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
